calc_core: RTL and testbench

4-bit calculator engine that sits directly downstream of the SPI slave front end. It consumes the slave's `write_vld`/`addr`/`data_w` write strobes, runs an operand–operator–operand–equals state machine, and drives the 8-bit result back to the slave on `data_r`, which is shifted out on the next read transaction. It runs on the system clock, asynchronous to `sclk`, and synchronises the slave's strobe internally.

---
 rtl/calc_core.sv | 192 +++++++++++++++++++
 tb/tb_calc_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_core.sv
// calc_core: 4-bit operand/operator/operand/equals calculator behind an SPI slave.
// Ports:
//   clk        - system clock (>= 8x sclk)
//   rst        - asynchronous active-high reset
//   write_vld  - write strobe from the SPI slave (sclk domain)
//   addr       - register address (0x01 digit, 0x02 operator)
//   data_w     - write data
//   data_r     - result register read back by the SPI slave
//   result_vld - high while a valid result is held
//   busy       - high while a multiply is in progress
//   err        - sticky sequence/format error flag
module calc_core (
   input  logic       clk,
   input  logic       rst,
   input  logic       write_vld,
   input  logic [6:0] addr,
   input  logic [7:0] data_w,
   output logic [7:0] data_r,
   output logic       result_vld,
   output logic       busy,
   output logic       err
);

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned CNT_W  = 2;

   localparam logic [ADDR_W-1:0] ADDR_DIGIT = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_OPER  = 7'h02;
   localparam logic [DATA_W-1:0] CODE_ADD   = 8'h2B;
   localparam logic [DATA_W-1:0] CODE_SUB   = 8'h2D;
   localparam logic [DATA_W-1:0] CODE_MUL   = 8'h2A;
   localparam logic [DATA_W-1:0] CODE_EQ    = 8'h3D;
   localparam logic [DATA_W-1:0] CODE_CLR   = 8'h43;
   localparam logic [DATA_W-1:0] RES_ERR    = 8'hEE;

   typedef enum logic [2:0] {S_A, S_OP, S_B, S_EQ, S_MUL, S_DONE, S_ERR} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

   // Strobe synchroniser and rising-edge detector
   logic              r_sync1, r_sync2, r_sync3;
   logic              r_wr_pulse;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              w_rise;

   // Calculator state
   state_t            r_state;
   op_t               r_op;
   logic [NIB_W-1:0]  r_a, r_b;
   logic [DATA_W-1:0] r_acc, r_mcand;
   logic [NIB_W-1:0]  r_mplr;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_data_r;
   logic              r_result_vld, r_busy, r_err;

   // Write classification
   logic              w_is_digit, w_is_oper, w_is_arith;
   logic              w_clr, w_live, w_dig_ok, w_opr_ok, w_eq_ok, w_error;
   op_t               w_op_sel;
   logic [DATA_W-1:0] w_sum, w_diff, w_acc_nxt;

   assign w_rise = r_sync2 & ~r_sync3;

   // Flops reset to 1 so a strobe held high across reset release is not seen as an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_sync3    <= 1'b1;
         r_wr_pulse <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
      end else begin
         r_sync1    <= write_vld;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_wr_pulse <= w_rise;
         if (w_rise) begin
            r_addr <= addr;
            r_data <= data_w;
         end
      end
   end

   assign w_is_digit = (r_addr == ADDR_DIGIT);
   assign w_is_oper  = (r_addr == ADDR_OPER);
   assign w_is_arith = (r_data == CODE_ADD) || (r_data == CODE_SUB) || (r_data == CODE_MUL);

   always_comb begin
      w_op_sel = OP_ADD;
      case (r_data)
         CODE_SUB: w_op_sel = OP_SUB;
         CODE_MUL: w_op_sel = OP_MUL;
         default:  w_op_sel = OP_ADD;
      endcase
   end

   // S_MUL swallows everything, S_ERR only honours clear
   assign w_clr    = r_wr_pulse & w_is_oper & (r_data == CODE_CLR) & (r_state != S_MUL);
   assign w_live   = r_wr_pulse & (w_is_digit | w_is_oper) & (r_state != S_MUL) & (r_state != S_ERR);
   assign w_dig_ok = w_live & w_is_digit & (r_data[DATA_W-1:NIB_W] == '0);
   assign w_opr_ok = w_live & w_is_oper & (r_state == S_OP) & w_is_arith;
   assign w_eq_ok  = w_live & w_is_oper & (r_state == S_EQ) & (r_data == CODE_EQ);
   assign w_error  = w_live & ~w_clr & ~w_dig_ok & ~w_opr_ok & ~w_eq_ok;

   assign w_sum     = DATA_W'({4'b0, r_a}) + DATA_W'({4'b0, r_b});
   assign w_diff    = DATA_W'({4'b0, r_a}) - DATA_W'({4'b0, r_b});
   assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

   // Sequencer: data_r only moves on result, error or clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_A;
         r_op         <= OP_ADD;
         r_a          <= '0;
         r_b          <= '0;
         r_acc        <= '0;
         r_mcand      <= '0;
         r_mplr       <= '0;
         r_cnt        <= '0;
         r_data_r     <= '0;
         r_result_vld <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
      end else if (r_state == S_MUL) begin
         r_acc   <= w_acc_nxt;
         r_mcand <= r_mcand << 1;
         r_mplr  <= r_mplr >> 1;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (r_cnt == CNT_W'(3)) begin
            r_data_r     <= w_acc_nxt;
            r_result_vld <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_DONE;
         end
      end else if (w_clr) begin
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= OP_ADD;
         r_data_r     <= '0;
         r_err        <= 1'b0;
         r_result_vld <= 1'b0;
         r_state      <= S_A;
      end else if (w_error) begin
         r_err        <= 1'b1;
         r_data_r     <= RES_ERR;
         r_result_vld <= 1'b0;
         r_state      <= S_ERR;
      end else if (w_dig_ok) begin
         if ((r_state == S_B) || (r_state == S_EQ)) begin
            r_b     <= r_data[NIB_W-1:0];
            r_state <= S_EQ;
         end else begin
            r_a          <= r_data[NIB_W-1:0];
            r_result_vld <= 1'b0;
            r_state      <= S_OP;
         end
      end else if (w_opr_ok) begin
         r_op    <= w_op_sel;
         r_state <= S_B;
      end else if (w_eq_ok) begin
         case (r_op)
            OP_ADD: begin
               r_data_r     <= w_sum;
               r_result_vld <= 1'b1;
               r_state      <= S_DONE;
            end
            OP_SUB: begin
               r_data_r     <= w_diff;
               r_result_vld <= 1'b1;
               r_state      <= S_DONE;
            end
            default: begin
               r_acc   <= '0;
               r_mcand <= DATA_W'({4'b0, r_a});
               r_mplr  <= r_b;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_state <= S_MUL;
            end
         endcase
      end
   end

   assign data_r     = r_data_r;
   assign result_vld = r_result_vld;
   assign busy       = r_busy;
   assign err        = r_err;

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: scoreboard bench for calc_core. Each write queues the output
// changes it should cause (with the edge on which they appear); a monitor pops
// and compares whenever the DUT outputs change.
module tb_calc_core;

   logic       clk;
   logic       rst;
   logic       write_vld;
   logic [6:0] addr;
   logic [7:0] data_w;
   logic [7:0] data_r;
   logic       result_vld;
   logic       busy;
   logic       err;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       rv;
      logic       bz;
      logic       er;
   } exp_t;

   exp_t sb[$];
   exp_t stage[$];
   int   errors = 0;
   int   checks = 0;
   int   edge_cnt = 0;

   calc_core dut (
      .clk        (clk),
      .rst        (rst),
      .write_vld  (write_vld),
      .addr       (addr),
      .data_w     (data_w),
      .data_r     (data_r),
      .result_vld (result_vld),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Queue an expected output change, rel edges after the next write's strobe rise
   task automatic push_exp(input int rel, input logic [7:0] d, input logic rv,
                           input logic bz, input logic er);
      exp_t e;
      e.cyc = rel; e.d = d; e.rv = rv; e.bz = bz; e.er = er;
      stage.push_back(e);
   endtask

   // One SPI write: strobe held 8 clk, then low 5 clk; optional reset at edge rst_at
   task automatic wr(input logic [6:0] a, input logic [7:0] d, input int rst_at);
      exp_t e;
      int   t0;
      @(negedge clk);
      addr = a; data_w = d; write_vld = 1'b1;
      t0 = edge_cnt;
      while (stage.size() > 0) begin
         e = stage.pop_front();
         e.cyc = e.cyc + t0;
         sb.push_back(e);
      end
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 8) write_vld = 1'b0;
         if (rst_at != 0 && i == rst_at) begin
            rst = 1'b1;
            sb.delete();
         end
      end
   endtask

   task automatic idle(input string name);
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data_r"}, 32'(data_r), 32'h00);
      chk({tag, "_result_vld"}, 32'(result_vld), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // Monitor: every output change must match the head of the scoreboard
   initial begin
      logic [10:0] prev, cur;
      exp_t        e;
      prev = 'x;
      forever begin
         @(negedge clk);
         cur = {data_r, result_vld, busy, err};
         if (!rst && cur !== prev) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: got d=%h rv=%b bz=%b er=%b @%0d, expected no change",
                        data_r, result_vld, busy, err, edge_cnt);
            end else begin
               e = sb.pop_front();
               if (cur !== {e.d, e.rv, e.bz, e.er} || edge_cnt != e.cyc) begin
                  errors++;
                  $display("FAIL scoreboard: got d=%h rv=%b bz=%b er=%b @%0d, expected d=%h rv=%b bz=%b er=%b @%0d",
                           data_r, result_vld, busy, err, edge_cnt, e.d, e.rv, e.bz, e.er, e.cyc);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic pulse_seen;
      // Reset with strobe held high across release; an operator here would error if seen
      rst = 1'b1; write_vld = 1'b1; addr = 7'h02; data_w = 8'h2B;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      pulse_seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (dut.r_wr_pulse) pulse_seen = 1'b1;
      end
      chk("no_pulse_at_release", 32'(pulse_seen), 32'd0);
      chk_reset_vals("reset");
      write_vld = 1'b0;
      repeat (5) @(negedge clk);

      // 7 + 9
      wr(7'h01, 8'h07, 0);
      wr(7'h02, 8'h2B, 0);
      wr(7'h01, 8'h09, 0);
      push_exp(4, 8'h10, 1, 0, 0); wr(7'h02, 8'h3D, 0);
      idle("add_done");

      // 3 - 5, then a digit from S_DONE, then 2 + 1 proves S_OP with A=2
      push_exp(4, 8'h10, 0, 0, 0); wr(7'h01, 8'h03, 0);
      wr(7'h02, 8'h2D, 0);
      wr(7'h01, 8'h05, 0);
      push_exp(4, 8'hFE, 1, 0, 0); wr(7'h02, 8'h3D, 0);
      push_exp(4, 8'hFE, 0, 0, 0); wr(7'h01, 8'h02, 0);
      wr(7'h02, 8'h2B, 0);
      wr(7'h01, 8'h01, 0);
      push_exp(4, 8'h03, 1, 0, 0); wr(7'h02, 8'h3D, 0);
      idle("sub_done");

      // 0 - 15 with B overwritten in S_EQ
      push_exp(4, 8'h03, 0, 0, 0); wr(7'h01, 8'h00, 0);
      wr(7'h02, 8'h2D, 0);
      wr(7'h01, 8'h03, 0);
      wr(7'h01, 8'h0F, 0);
      push_exp(4, 8'hF1, 1, 0, 0); wr(7'h02, 8'h3D, 0);
      idle("sub_wrap");

      // 15 * 15: busy N+1..N+4, result at N+5
      push_exp(4, 8'hF1, 0, 0, 0); wr(7'h01, 8'h0F, 0);
      wr(7'h02, 8'h2A, 0);
      wr(7'h01, 8'h0F, 0);
      push_exp(4, 8'hF1, 0, 1, 0);
      push_exp(8, 8'hE1, 1, 0, 0); wr(7'h02, 8'h3D, 0);
      idle("mul_done");

      // Error path
      push_exp(4, 8'h00, 0, 0, 0); wr(7'h02, 8'h43, 0);
      push_exp(4, 8'hEE, 0, 0, 1); wr(7'h02, 8'h2B, 0);
      wr(7'h01, 8'h04, 0);
      push_exp(4, 8'h00, 0, 0, 0); wr(7'h02, 8'h43, 0);
      push_exp(4, 8'hEE, 0, 0, 1); wr(7'h01, 8'h12, 0);
      push_exp(4, 8'h00, 0, 0, 0); wr(7'h02, 8'h43, 0);
      wr(7'h01, 8'h01, 0);
      push_exp(4, 8'hEE, 0, 0, 1); wr(7'h02, 8'h3D, 0);
      push_exp(4, 8'h00, 0, 0, 0); wr(7'h02, 8'h43, 0);
      wr(7'h01, 8'h01, 0);
      push_exp(4, 8'hEE, 0, 0, 1); wr(7'h02, 8'h41, 0);
      push_exp(4, 8'h00, 0, 0, 0); wr(7'h02, 8'h43, 0);
      wr(7'h01, 8'h01, 0);
      wr(7'h02, 8'h2B, 0);
      push_exp(4, 8'hEE, 0, 0, 1); wr(7'h02, 8'h2D, 0);
      push_exp(4, 8'h00, 0, 0, 0); wr(7'h02, 8'h43, 0);
      idle("errors");

      // Ignored address, A overwrite in S_OP, then 6 + 1
      wr(7'h01, 8'h02, 0);
      wr(7'h05, 8'h55, 0);
      wr(7'h01, 8'h06, 0);
      wr(7'h02, 8'h2B, 0);
      wr(7'h01, 8'h01, 0);
      push_exp(4, 8'h07, 1, 0, 0); wr(7'h02, 8'h3D, 0);
      idle("ignored_write");

      // 6 * 9 interrupted by reset during S_MUL
      push_exp(4, 8'h07, 0, 0, 0); wr(7'h01, 8'h06, 0);
      wr(7'h02, 8'h2A, 0);
      wr(7'h01, 8'h09, 0);
      push_exp(4, 8'h07, 0, 1, 0);
      push_exp(8, 8'h36, 1, 0, 0); wr(7'h02, 8'h3D, 6);
      chk_reset_vals("mul_rst");
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk_reset_vals("post_rst");
      idle("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
